// File: rtl/dsp_lane_array.sv
// Multi-lane pipelined multiply/accumulate for the matrix multiplier's DSP interface.
// All lanes share one stallable control/valid pipe; each lane holds its own data pipe.

module dsp_lane #(
   parameter int PIPE_STAGES = 2,
   parameter int SIGNED      = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic [17:0] a,
   input  logic [17:0] b,
   input  logic        acc_en,
   input  logic        acc_clr,
   output logic [36:0] out
);
   logic [17:0] a_q, a_d, b_q, b_d;
   logic [35:0] prod_c, prod_last;
   logic [36:0] prod_ext, out_q, out_d;

   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (ce) begin
         a_d = a;
         b_d = b;
      end
   end

   // 36-bit wide operands so the truncated product is exact in both modes.
   if (SIGNED != 0) begin : g_signed
      assign prod_c   = {{18{a_q[17]}}, a_q} * {{18{b_q[17]}}, b_q};
      assign prod_ext = {prod_last[35], prod_last};
   end else begin : g_unsigned
      assign prod_c   = {18'd0, a_q} * {18'd0, b_q};
      assign prod_ext = {1'b0, prod_last};
   end

   if (PIPE_STAGES > 2) begin : g_pipe
      logic [PIPE_STAGES-1:2][35:0] prod_q, prod_d;
      always_comb begin
         prod_d = prod_q;
         if (ce) begin
            prod_d[2] = prod_c;
            for (int i = 3; i < PIPE_STAGES; i++) prod_d[i] = prod_q[i-1];
         end
      end
      always_ff @(posedge clk) begin
         if (rst) prod_q <= '0;
         else     prod_q <= prod_d;
      end
      assign prod_last = prod_q[PIPE_STAGES-1];
   end else begin : g_nopipe
      assign prod_last = prod_c;
   end

   always_comb begin
      out_d = out_q;
      if (ce) out_d = (acc_en && !acc_clr) ? out_q + prod_ext : prod_ext;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         out_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         out_q <= out_d;
      end
   end

   assign out = out_q;
endmodule

module dsp_lane_array #(
   parameter int LANES       = 5,
   parameter int PIPE_STAGES = 2,
   parameter int SIGNED      = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          dsp_ce,
   input  logic [0:LANES-1][17:0]        dsp_a0,
   input  logic [0:LANES-1][17:0]        dsp_b0,
   input  logic                          acc_en,
   input  logic                          acc_clr,
   output logic [0:LANES-1][36:0]        dsp_out,
   output logic                          dsp_valid
);
   if (PIPE_STAGES < 2) begin : g_bad_cfg
      $error("dsp_lane_array: PIPE_STAGES must be >= 2");
   end

   // Stage k of each pipe holds the beat captured k-1 ce edges ago.
   logic [PIPE_STAGES:1]   vld_pipe_q, vld_pipe_d;
   logic [PIPE_STAGES-1:1] en_pipe_q, en_pipe_d, clr_pipe_q, clr_pipe_d;
   logic [PIPE_STAGES-1:0] en_shift, clr_shift;

   assign en_shift  = {en_pipe_q, acc_en};
   assign clr_shift = {clr_pipe_q, acc_clr};

   always_comb begin
      vld_pipe_d = vld_pipe_q;
      en_pipe_d  = en_pipe_q;
      clr_pipe_d = clr_pipe_q;
      if (dsp_ce) begin
         vld_pipe_d = {vld_pipe_q[PIPE_STAGES-1:1], 1'b1};
         en_pipe_d  = en_shift[PIPE_STAGES-2:0];
         clr_pipe_d = clr_shift[PIPE_STAGES-2:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_q <= '0;
         en_pipe_q  <= '0;
         clr_pipe_q <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         en_pipe_q  <= en_pipe_d;
         clr_pipe_q <= clr_pipe_d;
      end
   end

   assign dsp_valid = vld_pipe_q[PIPE_STAGES];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      dsp_lane #(.PIPE_STAGES(PIPE_STAGES), .SIGNED(SIGNED)) u_lane (
         .clk     (clk),
         .rst     (rst),
         .ce      (dsp_ce),
         .a       (dsp_a0[l]),
         .b       (dsp_b0[l]),
         .acc_en  (en_pipe_q[PIPE_STAGES-1]),
         .acc_clr (clr_pipe_q[PIPE_STAGES-1]),
         .out     (dsp_out[l])
      );
   end
endmodule

// File: tb/tb_dsp_lane_array.sv
// Directed bench for dsp_lane_array: unsigned and signed instances share stimulus.
module tb_dsp_lane_array;
   localparam int LANES = 5;

   logic clk = 1'b0;
   logic rst, dsp_ce, acc_en, acc_clr;
   logic [0:LANES-1][17:0] dsp_a0, dsp_b0;
   logic [0:LANES-1][36:0] out_u, out_s;
   logic valid_u, valid_s;
   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   dsp_lane_array #(.LANES(LANES), .PIPE_STAGES(2), .SIGNED(0)) u_dut_u (
      .clk(clk), .rst(rst), .dsp_ce(dsp_ce), .dsp_a0(dsp_a0), .dsp_b0(dsp_b0),
      .acc_en(acc_en), .acc_clr(acc_clr), .dsp_out(out_u), .dsp_valid(valid_u));

   dsp_lane_array #(.LANES(LANES), .PIPE_STAGES(2), .SIGNED(1)) u_dut_s (
      .clk(clk), .rst(rst), .dsp_ce(dsp_ce), .dsp_a0(dsp_a0), .dsp_b0(dsp_b0),
      .acc_en(acc_en), .acc_clr(acc_clr), .dsp_out(out_s), .dsp_valid(valid_s));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic [17:0] a, input logic [17:0] b);
      for (int l = 0; l < LANES; l++) begin
         dsp_a0[l] = a;
         dsp_b0[l] = b;
      end
   endtask

   initial begin
      rst = 1'b1; dsp_ce = 1'b1; acc_en = 1'b0; acc_clr = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         dsp_a0[l] = 18'($urandom);
         dsp_b0[l] = 18'($urandom);
      end
      tick(); tick();
      for (int l = 0; l < LANES; l++) chk($sformatf("rst_out%0d", l), out_u[l], 0);
      chk("rst_out_s0", out_s[0], 0);
      chk("rst_valid", valid_u, 0);
      chk("rst_valid_s", valid_s, 0);

      // valid needs two ce edges after reset
      rst = 1'b0;
      tick();
      chk("valid_1edge", valid_u, 0);
      tick();
      chk("valid_2edge", valid_u, 1);

      // single product, one-edge lag after capture
      set_all(18'd0, 18'd0);
      dsp_a0[0] = 18'd1;   dsp_b0[0] = 18'd1;
      dsp_a0[4] = 18'd255; dsp_b0[4] = 18'd255;
      tick(); tick();
      chk("single_l0", out_u[0], 64'd1);
      chk("single_l4", out_u[4], 64'hFE01);
      chk("single_l1", out_u[1], 64'd0);

      // stall holds everything; operands presented during stall are not captured
      dsp_a0[2] = 18'd3; dsp_b0[2] = 18'd5;
      tick();
      chk("stall_pre", out_u[2], 64'd0);
      dsp_ce = 1'b0;
      dsp_a0[2] = 18'd7;
      for (int i = 0; i < 4; i++) tick();
      chk("stall_hold", out_u[2], 64'd0);
      chk("stall_valid", valid_u, 1);
      dsp_ce = 1'b1;
      tick();
      chk("stall_release", out_u[2], 64'd15);
      dsp_ce = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("stall_hold15", out_u[2], 64'd15);

      // 16-beat accumulate, then clear+en together
      dsp_ce = 1'b1;
      set_all(18'd1, 18'd1);
      for (int i = 0; i < 16; i++) begin
         acc_clr = (i == 0);
         acc_en  = (i != 0);
         tick();
      end
      acc_clr = 1'b1; acc_en = 1'b1;
      set_all(18'd2, 18'd2);
      tick();
      for (int l = 0; l < LANES; l++) chk($sformatf("acc16_l%0d", l), out_u[l], 64'h10);
      tick();
      chk("clr_wins", out_u[0], 64'd4);
      chk("clr_wins_l3", out_u[3], 64'd4);

      // modulo 2^37 wrap
      set_all(18'h3FFFF, 18'h3FFFF);
      acc_clr = 1'b1; acc_en = 1'b0;
      tick();
      acc_clr = 1'b0; acc_en = 1'b1;
      tick();
      chk("wrap_1", out_u[1], 64'hFFFF80001);
      tick();
      chk("wrap_2", out_u[1], 64'h1FFFF00002);
      tick();
      chk("wrap_3", out_u[1], 64'h0FFFE80003);
      chk("wrap_3_s", out_s[1], 64'h3);

      // signed product sign-extended to 37 bits, then accumulate
      acc_en = 1'b0; acc_clr = 1'b0;
      set_all(18'h3FFFE, 18'd3);
      tick();
      acc_en = 1'b1;
      set_all(18'd3, 18'd3);
      tick();
      chk("signed_neg", out_s[0], 64'h1FFFFFFFFA);
      chk("unsigned_same", out_u[0], 64'hBFFFA);
      tick();
      chk("signed_acc", out_s[0], 64'h3);

      // reset mid-pipeline discards in-flight beats
      acc_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_all(18'(5 + i), 18'd7);
         tick();
      end
      rst = 1'b1;
      tick();
      for (int l = 0; l < LANES; l++) chk($sformatf("midrst_l%0d", l), out_u[l], 0);
      chk("midrst_valid", valid_u, 0);
      rst = 1'b0;
      tick();
      chk("postrst_l0", out_u[0], 0);
      chk("postrst_l4", out_u[4], 0);
      chk("postrst_valid", valid_u, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/dsp_lane_array.md
Name: dsp_lane_array

Overview:
- Multi-lane pipelined multiply/accumulate responder on the DSP side of the matrix multiplier's dsp_a0/dsp_b0/dsp_ce/dsp_out interface.
- Each lane registers its operand pair, multiplies, and optionally accumulates.
- Each lane returns a 37-bit result after a fixed number of clock-enabled cycles.
- Replaces the behavioural DSP model with synthesizable, stallable RTL.

Parameters:
- LANES, 5, number of independent multiply lanes.
- PIPE_STAGES, 2, ce-qualified edges from operand capture to result on dsp_out. Minimum is 2; values below 2 are a elaboration error.
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands, with the product sign-extended to 37 bits.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- dsp_ce  input  1  clock enable. The whole pipeline advances only on edges where dsp_ce=1.
- dsp_a0  input  [0:LANES-1] x 18  operand A per lane.
- dsp_b0  input  [0:LANES-1] x 18  operand B per lane.
- acc_en  input  1  accumulate beat. Applies to all lanes and travels with the operands.
- acc_clr  input  1  start a new accumulation. Overrides acc_en and travels with the operands.
- dsp_out  output  [0:LANES-1] x 37  per-lane result.
- dsp_valid  output  1  high when dsp_out holds a result from a captured beat.

Behaviour:
- Reset:
  - On a clk edge with rst=1, all pipeline registers, dsp_out[*], and the valid pipe clear to 0, regardless of dsp_ce.
  - rst has priority over dsp_ce. Data in flight at reset is discarded.
- Stage 1 (capture): on a clk edge with dsp_ce=1, register dsp_a0, dsp_b0, acc_en, acc_clr, and a valid bit of 1.
- Product stages:
  - Stages 2..PIPE_STAGES-1 carry the 36-bit product a*b plus its control and valid bits.
  - With PIPE_STAGES=2, the multiply sits combinationally between the capture register and the output register.
- Output stage (last ce edge), per lane, with the product extended to 37 bits (zero- or sign-extended per SIGNED):
  - acc_clr=1: dsp_out = product.
  - else acc_en=1: dsp_out = dsp_out + product, wrapping modulo 2^37. No saturation, no overflow flag.
  - else: dsp_out = product.
- Latency:
  - Operands sampled on ce edge k appear on dsp_out immediately after the PIPE_STAGES-th ce-high edge counting from k (k itself = 1).
  - Edges with dsp_ce=0 do not count.
- Stall (dsp_ce=0): every register holds, including dsp_out, dsp_valid, and the accumulators. dsp_out is not zeroed while idle.
- dsp_valid:
  - Is the valid bit of the output stage.
  - After reset it goes high only once PIPE_STAGES ce edges have occurred. It then stays high; the valid bit entering stage 1 is constant 1 on every ce edge.
- Simultaneous controls:
  - acc_en=1 and acc_clr=1 together → clear wins; result = product.
  - acc_en on the first beat after reset accumulates onto 0.
- Lanes are fully independent and share only the control pipe.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst=1 for 2 edges with random operands and dsp_ce=1 → all dsp_out=0 and dsp_valid=0. Deassert rst, then apply 1 ce edge → dsp_valid still 0; after the 2nd ce edge → dsp_valid=1.
- Single product (PIPE_STAGES=2, dsp_ce=1 continuous), lane0 a=1,b=1 and lane4 a=255,b=255 captured on edge k → after edge k+1, dsp_out[0]=1 and dsp_out[4]=0xFE01.
- Stall: capture a=3,b=5 (lane2) on one ce edge, then dsp_ce=0 for 4 cycles → dsp_out[2] and dsp_valid unchanged. Next ce edge → dsp_out[2]=15. Further ce=0 cycles → holds 15.
- Accumulate: 16 consecutive beats a=b=1 on all lanes, acc_clr=1 on beat 0 and acc_en=1 on beats 1-15 → final dsp_out[*]=0x10. A 17th beat with acc_clr=1 and acc_en=1, a=2,b=2 → 4.
- Wrap: a=b=0x3FFFF unsigned, acc_clr then 2 acc_en beats → dsp_out = 0xFFFF80001, then 0x1FFFF00002, then 0x0FFFE80003 (mod 2^37).
- Signed (SIGNED=1): a=0x3FFFE (-2), b=3 → dsp_out=0x1FFFFFFFFA. Then a second beat with acc_en=1, a=b=3 → 0x3.
- Reset mid-pipeline: capture 5 nonzero beats, assert rst for 1 edge while dsp_ce=1 → that edge yields all zeros and dsp_valid=0. The next 1 ce edge leaves dsp_out=0; in-flight data never appears.
